store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MIPS core's data-memory port and the data memory. Accepts each store the core issues (`memwrite`, `dataadr`, `writedata`) into a small in-order FIFO and drains it to memory over a req/ack handshake, so slow memory does not stall stores until the buffer fills. Loads check the buffer, and the youngest matching pending store is forwarded so the core never reads stale memory.

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Power of two, ≥ 2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-low. 0 = reset, sampled on the rising edge of `clk`.
- `memwrite` in 1: core store request.
- `dataadr` in AW: store address, word-aligned; bits [1:0] are ignored.
- `writedata` in DW: store data.
- `full` out 1: buffer full. The core must hold the store while it is high.
- `ld_adr` in AW: core load address.
- `ld_hit` out 1: a pending store matches `ld_adr[AW-1:2]`.
- `ld_data` out DW: data of the youngest matching entry. 0 when there is no hit.
- `mem_req` out 1: write request to data memory.
- `mem_adr` out AW: head entry address.
- `mem_wdata` out DW: head entry data.
- `mem_ack` in 1: memory accepted the write. Sampled only while `mem_req` is high.
- `empty` out 1: no pending entries.
- `count` out $clog2(DEPTH)+1: number of valid entries.

## Operation
Enqueue:
- A store is enqueued on an edge where `memwrite` && !`full`.
- The entry is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- `memwrite` while `full` is ignored. The core holds it and retries.

Dequeue:
- On an edge where `mem_req` && `mem_ack`, `rd_ptr` increments modulo DEPTH.

Count:
- Enqueue only: `count` + 1.
- Dequeue only: `count` − 1.
- Both on the same edge: `count` unchanged, both pointers advance.
- `full` = (`count` == DEPTH) and `empty` = (`count` == 0), both decoded from the registered count.
- When full and acked on the same edge, no enqueue is accepted that edge. The slot becomes usable the next cycle.

Drain FSM, two states:
- IDLE: `mem_req` = 0. Go to REQ when `count` != 0.
- REQ: `mem_req` = 1, `mem_adr`/`mem_wdata` = head entry.
  - On `mem_ack`, dequeue.
  - Stay in REQ if the post-dequeue count is > 0, otherwise go to IDLE.
  - Without `mem_ack`, hold; `mem_adr`/`mem_wdata` must not change.

Forwarding:
- Combinational compare of `ld_adr[AW-1:2]` against all valid entries.
- The youngest match, closest to `wr_ptr`, wins.
- Only registered entries are compared. A store enqueued on the same edge is not visible until the next cycle.

Reset (`reset` = 0):
- Pointers, `count` and FSM return to 0/IDLE.
- Outputs: `mem_req` = 0, `full` = 0, `empty` = 1, `count` = 0, `ld_hit` = 0, `ld_data` = 0, `mem_adr`/`mem_wdata` = 0.
- Entry storage need not be cleared, but valid bits are cleared.
- A reset during REQ abandons the pending write, and `mem_req` drops on that edge.

## Timing
- Store into an empty buffer at edge N: `mem_req` is high after edge N+1. Store-to-request latency is 1 cycle.
- Throughput: one drain per cycle while `mem_ack` is held high.
- Back-to-back acks keep `mem_req` high continuously.
- `ld_hit`/`ld_data` are combinational from `ld_adr` and the registered entries, so they settle within the same cycle.
- `full` asserts the cycle after the DEPTH-th enqueue.
- Pointers wrap from DEPTH−1 to 0 with no gap.

## Structure
- Package `store_buffer_pkg`:
  - `sb_entry_t` struct with fields {`adr` [AW-1:0], `data` [DW-1:0]}.
  - `sb_state_t` enum {SB_IDLE, SB_REQ}.
- One sub-module `sb_fifo`: entry array, valid bits, pointers and count, with push/pop/head and an entry-array read-out for forwarding.
- `store_buffer` holds the FSM and the forwarding priority logic.
- Instantiated between `top`'s core data port and the data memory.

## Test plan
- Reset held low for 2 cycles, then released -> `empty` = 1, `count` = 0, `mem_req` = 0, `full` = 0.
- Single store adr 76, data 7, `mem_ack` tied high -> `mem_req` asserts one cycle later with `mem_adr` = 76 and `mem_wdata` = 7, then deasserts; `empty` = 1 after the ack.
- 5 stores (adr 0,4,8,12,16), `mem_ack` = 0, DEPTH = 4 -> `full` = 1 after the 4th; the 5th is held; after one ack the 5th is accepted and drained in order 0,4,8,12,16.
- Stores adr 72 (data 3) then adr 72 (data 9), with `ld_adr` = 72 and no ack -> `ld_hit` = 1, `ld_data` = 9; `ld_adr` = 80 -> `ld_hit` = 0, `ld_data` = 0.
- Simultaneous enqueue and ack at `count` = 2 -> `count` stays 2, and the pointer wrap past DEPTH−1 preserves order.
- `reset` driven low while in REQ with 3 entries -> the next cycle shows `mem_req` = 0, `count` = 0, `ld_hit` = 0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer between the core data port and data memory.
// Entry widths are fixed here, so store_buffer/sb_fifo AW and DW must match SB_AW/SB_DW.
package store_buffer_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] adr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order entry storage for the store buffer: pointers, count, valid bits and
// a full read-out of the entry array so the top can search it for load forwarding.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head,
  output sb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PW-1:0]    wr_ptr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered count, so a slot freed by an ack is
  // only reusable on the following edge.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr         <= wr_ptr + PW'(1);
        valid[wr_ptr]  <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr         <= rd_ptr + PW'(1);
        valid[rd_ptr]  <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: queues core stores, drains them to data memory over
// req/ack, and forwards the youngest pending store to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  output logic                   full,
  input  logic [AW-1:0]          ld_adr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_adr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_t        state;
  sb_state_t        state_next;
  sb_entry_t        push_entry;
  sb_entry_t        head;
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    idx;
  logic             push_ok;
  logic             pop;
  logic             ld_adr_unused;

  assign push_entry    = '{adr: dataadr, data: writedata};
  assign push_ok       = memwrite && !full;
  assign pop           = mem_req && mem_ack;
  assign ld_adr_unused = ^ld_adr[1:0];

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (memwrite),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .valid      (valid),
    .wr_ptr     (wr_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stay in REQ across an ack when anything is left or arriving, so
  // back-to-back acks keep mem_req high without a bubble.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_adr    = '0;
    mem_wdata  = '0;
    case (state)
      SB_IDLE: begin
        if (count != '0) state_next = SB_REQ;
      end
      SB_REQ: begin
        mem_req   = 1'b1;
        mem_adr   = head.adr;
        mem_wdata = head.data;
        if (mem_ack && (count <= CW'(1)) && !push_ok) state_next = SB_IDLE;
      end
      default: state_next = SB_IDLE;
    endcase
  end

  // Walk valid slots oldest to youngest (ending just behind wr_ptr) so the
  // last match, i.e. the youngest store, wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (valid[idx] && (entries[idx].adr[AW-1:2] == ld_adr[AW-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = entries[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: a queue of expected drains is filled as
// stores are accepted and emptied as the DUT presents writes to memory.
module tb_store_buffer;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        full;
  logic [31:0] ld_adr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  exp_t sb_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .full      (full),
    .ld_adr    (ld_adr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_req   (mem_req),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    ld_adr = '0; mem_ack = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %0h expected 1", empty); end
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %0h expected 0", mem_req); end
    checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %0h expected 0", full); end
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_ld: got hit=%0h data=%0h expected 0/0", ld_hit, ld_data); end
    checks++; if (mem_adr !== 32'd0 || mem_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_bus: got %0h/%0h expected 0/0", mem_adr, mem_wdata); end
  endtask

  task automatic test_single_store();
    mem_ack = 1'b1;
    memwrite = 1'b1; dataadr = 32'd76; writedata = 32'd7;
    sb_q.push_back('{adr: 32'd76, data: 32'd7});
    cycle();
    memwrite = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL single_req_latency: got %0h expected 0", mem_req); end
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
    cycle();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL single_req: got %0h expected 1", mem_req); end
    e = sb_q.pop_front();
    checks++; if (mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL single_drain: got %0d/%0d expected %0d/%0d", mem_adr, mem_wdata, e.adr, e.data); end
    cycle();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL single_req_drop: got %0h expected 0", mem_req); end
    checks++; if (empty !== 1'b1) begin failures++; $display("[TB] FAIL single_empty: got %0h expected 1", empty); end
    mem_ack = 1'b0;
  endtask

  task automatic test_full();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memwrite = 1'b1; dataadr = 32'(4 * i); writedata = 32'(100 + i);
      sb_q.push_back('{adr: 32'(4 * i), data: 32'(100 + i)});
      cycle();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL full_after_4: got %0h expected 1", full); end
    dataadr = 32'd16; writedata = 32'd104;
    cycle(); cycle();
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL full_held_count: got %0d expected 4", count); end
    checks++; if (mem_adr !== 32'd0 || mem_wdata !== 32'd100) begin failures++; $display("[TB] FAIL full_head_hold: got %0d/%0d expected 0/100", mem_adr, mem_wdata); end
    mem_ack = 1'b1;
    e = sb_q.pop_front();
    checks++; if (mem_req !== 1'b1 || mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL full_first_drain: got req=%0h %0d/%0d expected 1 %0d/%0d", mem_req, mem_adr, mem_wdata, e.adr, e.data); end
    cycle();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd3 || full !== 1'b0) begin failures++; $display("[TB] FAIL full_ack_no_enq: got count=%0d full=%0h expected 3/0", count, full); end
    sb_q.push_back('{adr: 32'd16, data: 32'd104});
    cycle();
    memwrite = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL full_retry_accept: got %0d expected 4", count); end
    mem_ack = 1'b1;
    for (int b = 0; b < 20 && sb_q.size() > 0; b++) begin
      if (mem_req === 1'b1) begin
        e = sb_q.pop_front();
        checks++; if (mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL full_drain_order: got %0d/%0d expected %0d/%0d", mem_adr, mem_wdata, e.adr, e.data); end
      end
      cycle();
    end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL full_drain_timeout: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    checks++; if (empty !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL full_drained: got empty=%0h req=%0h expected 1/0", empty, mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_forwarding();
    mem_ack = 1'b0;
    memwrite = 1'b1; dataadr = 32'd72; writedata = 32'd3;
    sb_q.push_back('{adr: 32'd72, data: 32'd3});
    cycle();
    ld_adr = 32'd72;
    dataadr = 32'd72; writedata = 32'd9;
    sb_q.push_back('{adr: 32'd72, data: 32'd9});
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd3) begin failures++; $display("[TB] FAIL fwd_same_edge: got hit=%0h data=%0d expected 1/3", ld_hit, ld_data); end
    cycle();
    memwrite = 1'b0;
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin failures++; $display("[TB] FAIL fwd_youngest: got hit=%0h data=%0d expected 1/9", ld_hit, ld_data); end
    ld_adr = 32'd80;
    #1;
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin failures++; $display("[TB] FAIL fwd_miss: got hit=%0h data=%0d expected 0/0", ld_hit, ld_data); end
    ld_adr = 32'd74;
    #1;
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd9) begin failures++; $display("[TB] FAIL fwd_low_bits: got hit=%0h data=%0d expected 1/9", ld_hit, ld_data); end
    mem_ack = 1'b1;
    for (int b = 0; b < 20 && sb_q.size() > 0; b++) begin
      if (mem_req === 1'b1) begin
        e = sb_q.pop_front();
        checks++; if (mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL fwd_drain: got %0d/%0d expected %0d/%0d", mem_adr, mem_wdata, e.adr, e.data); end
      end
      cycle();
    end
    checks++; if (sb_q.size() != 0) begin failures++; $display("[TB] FAIL fwd_drain_timeout: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    mem_ack = 1'b0;
    ld_adr = '0;
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b0;
    memwrite = 1'b1; dataadr = 32'd200; writedata = 32'd1;
    sb_q.push_back('{adr: 32'd200, data: 32'd1});
    cycle();
    dataadr = 32'd204; writedata = 32'd2;
    sb_q.push_back('{adr: 32'd204, data: 32'd2});
    cycle();
    mem_ack = 1'b1;
    for (int j = 0; j < 6; j++) begin
      dataadr = 32'(208 + 4 * j); writedata = 32'(10 + j);
      sb_q.push_back('{adr: 32'(208 + 4 * j), data: 32'(10 + j)});
      #1;
      checks++; if (mem_req !== 1'b1 || count !== 3'd2) begin failures++; $display("[TB] FAIL b2b_steady: got req=%0h count=%0d expected 1/2", mem_req, count); end
      e = sb_q.pop_front();
      checks++; if (mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL b2b_order: got %0d/%0d expected %0d/%0d", mem_adr, mem_wdata, e.adr, e.data); end
      cycle();
    end
    memwrite = 1'b0;
    for (int b = 0; b < 20 && sb_q.size() > 0; b++) begin
      if (mem_req === 1'b1) begin
        e = sb_q.pop_front();
        checks++; if (mem_adr !== e.adr || mem_wdata !== e.data) begin failures++; $display("[TB] FAIL b2b_tail: got %0d/%0d expected %0d/%0d", mem_adr, mem_wdata, e.adr, e.data); end
      end
      cycle();
    end
    checks++; if (sb_q.size() != 0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL b2b_drained: got left=%0d empty=%0h expected 0/1", sb_q.size(), empty); sb_q.delete(); end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_in_req();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; dataadr = 32'(300 + 4 * i); writedata = 32'(31 + i);
      cycle();
    end
    memwrite = 1'b0;
    ld_adr = 32'd304;
    #1;
    checks++; if (mem_req !== 1'b1 || count !== 3'd3) begin failures++; $display("[TB] FAIL rst_pre_state: got req=%0h count=%0d expected 1/3", mem_req, count); end
    checks++; if (ld_hit !== 1'b1 || ld_data !== 32'd32) begin failures++; $display("[TB] FAIL rst_pre_fwd: got hit=%0h data=%0d expected 1/32", ld_hit, ld_data); end
    reset = 1'b0;
    cycle();
    checks++; if (mem_req !== 1'b0 || count !== 3'd0) begin failures++; $display("[TB] FAIL rst_in_req: got req=%0h count=%0d expected 0/0", mem_req, count); end
    checks++; if (ld_hit !== 1'b0 || ld_data !== 32'd0) begin failures++; $display("[TB] FAIL rst_fwd_clear: got hit=%0h data=%0d expected 0/0", ld_hit, ld_data); end
    checks++; if (empty !== 1'b1 || mem_adr !== 32'd0) begin failures++; $display("[TB] FAIL rst_outputs: got empty=%0h adr=%0d expected 1/0", empty, mem_adr); end
    reset = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full();
    test_forwarding();
    test_back_to_back();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
